// File: rtl/rx_pkg.sv
// Package rx_pkg
//  Shared definitions for the receive deframer: receiver FSM state encoding,
//  default block geometry and the on-line frame length.
//  Frame on the line: start(0), DATA_W payload bits MSB first, parity, stop(1).
package rx_pkg;

    localparam int DATA_W_DEF = 128;  // payload bits per frame
    localparam int ROWS_DEF   = 16;   // interleaver rows
    localparam int COLS_DEF   = 8;    // interleaver columns
    localparam int FRAME_BITS = 131;  // start + payload + parity + stop

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } rx_state_e;

endpackage

// File: rtl/block_deinterleaver.sv
// Module block_deinterleaver
//  Purely combinational ROWS x COLS index permutation that undoes the
//  transmitter's block interleave: blk[r*COLS+c] = rx[c*ROWS+r].
// Ports
//  rx   in   ROWS*COLS  interleaved word, in line order (first line bit at MSB)
//  blk  out  ROWS*COLS  deinterleaved block
module block_deinterleaver #(
    parameter int ROWS = 16,
    parameter int COLS = 8
) (
    input  logic [ROWS*COLS-1:0] rx,
    output logic [ROWS*COLS-1:0] blk
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            assign blk[r*COLS + c] = rx[c*ROWS + r];
        end
    end

endmodule

// File: rtl/rx_deframer.sv
// Module rx_deframer
//  Samples the serial line one bit per clock, finds frames, checks parity and
//  stop bit, deinterleaves the payload and presents it through a one-entry
//  valid/ready output register.
// Ports
//  clock        in   1       single clock, one line bit per cycle
//  resetn       in   1       asynchronous active-low reset
//  Rx_in        in   1       serial line, idle high
//  block_out    out  DATA_W  deinterleaved payload (held after accept)
//  block_valid  out  1       block_out holds an unconsumed block
//  block_ready  in   1       downstream accepts when block_valid & block_ready
//  parity_err   out  1       pulse: frame dropped, parity mismatch
//  framing_err  out  1       pulse: frame dropped, stop bit was 0
//  overflow     out  1       pulse: good frame dropped, output register full
//  busy         out  1       receiver is inside a frame
//  deint_in     out  DATA_W  raw line-order shift register (only with RX_DEBUG_TAP_EN)
// Configuration
//  RX_DEBUG_TAP_EN  when defined, exposes the shift register as port deint_in.
module rx_deframer
    import rx_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ROWS    = ROWS_DEF,
    parameter int COLS    = COLS_DEF,
    parameter bit PAR_ODD = 1'b0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              Rx_in,
    output logic [DATA_W-1:0] block_out,
    output logic              block_valid,
    input  logic              block_ready,
    output logic              parity_err,
    output logic              framing_err,
    output logic              overflow,
    output logic              busy
`ifdef RX_DEBUG_TAP_EN
    ,
    output logic [DATA_W-1:0] deint_in
`endif
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_e         state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_q;    // line order: first payload bit ends at MSB
    logic              par_acc;    // running XOR of payload bits
    logic              par_ok;     // parity verdict latched in PAR, used in STOP
    logic [DATA_W-1:0] deint_blk;

    block_deinterleaver #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_deint (
        .rx  (shift_q),
        .blk (deint_blk)
    );

    assign busy = (state != IDLE);

`ifdef RX_DEBUG_TAP_EN
    assign deint_in = shift_q;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_q     <= '0;
            par_acc     <= 1'b0;
            par_ok      <= 1'b0;
            block_out   <= '0;
            block_valid <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overflow    <= 1'b0;

            // NOTE: with non-blocking assignments the last write in the block
            // wins, so a delivery in STOP below overrides this accept-clear and
            // a block can be consumed and replaced in the same cycle.
            if (block_valid && block_ready) begin
                block_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!Rx_in) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        par_acc <= 1'b0;
                    end
                end

                DATA: begin
                    shift_q <= {shift_q[DATA_W-2:0], Rx_in};
                    par_acc <= par_acc ^ Rx_in;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state <= PAR;
                    end
                end

                PAR: begin
                    par_ok <= ((par_acc ^ PAR_ODD) == Rx_in);
                    state  <= STOP;
                end

                STOP: begin
                    // A 0 here is a framing error, never a new start bit.
                    state <= IDLE;
                    if (!Rx_in) begin
                        framing_err <= 1'b1;
                    end else if (!par_ok) begin
                        parity_err <= 1'b1;
                    end else if (block_valid && !block_ready) begin
                        overflow <= 1'b1;
                    end else begin
                        block_out   <= deint_blk;
                        block_valid <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_deframer.sv
// Testbench tb_rx_deframer
//  Drives whole frames onto Rx_in from a block-level description and checks
//  the deframer outputs one cycle after the stop bit against expectations from
//  a stimulus table, hand-written corner sequences and a frame-level model.
`timescale 1ns/1ps
module tb_rx_deframer;
    import rx_pkg::*;

    localparam int W    = 128;
    localparam int ROWS = 16;
    localparam int COLS = 8;
    localparam bit PAR_ODD = 1'b0;

    localparam logic [W-1:0] BLK_A = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [W-1:0] BLK_B = 128'hDEADBEEF_CAFEF00D_0F1E2D3C_4B5A6978;

    logic         clock = 1'b0;
    logic         resetn = 1'b1;
    logic         Rx_in = 1'b1;
    logic         block_ready = 1'b0;
    logic [W-1:0] block_out;
    logic         block_valid, parity_err, framing_err, overflow, busy;
`ifdef RX_DEBUG_TAP_EN
    logic [W-1:0] deint_in;
`endif

    always #5 clock = ~clock;

    rx_deframer #(.DATA_W(W), .ROWS(ROWS), .COLS(COLS), .PAR_ODD(PAR_ODD)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .Rx_in       (Rx_in),
        .block_out   (block_out),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .parity_err  (parity_err),
        .framing_err (framing_err),
        .overflow    (overflow),
        .busy        (busy)
`ifdef RX_DEBUG_TAP_EN
        ,
        .deint_in    (deint_in)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transmitter-side interleave: line word bit c*ROWS+r carries block bit r*COLS+c.
    function automatic logic [W-1:0] interleave(input logic [W-1:0] blk);
        logic [W-1:0] w;
        w = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                w[c*ROWS + r] = blk[r*COLS + c];
        return w;
    endfunction

    // Sends one frame; ready is rdy for the body and rdy_stop while the stop
    // bit is sampled. Returns at the negedge after the stop edge, line idle.
    task automatic send_frame(input logic [W-1:0] blk, input bit flip_par, input bit stop_bit,
                              input bit rdy, input bit rdy_stop);
        logic [W-1:0] w;
        logic         par;
        w   = interleave(blk);
        par = PAR_ODD ^ (^w) ^ flip_par;
        @(negedge clock); Rx_in = 1'b0; block_ready = rdy;
        for (int k = 0; k < W; k++) begin
            @(negedge clock); Rx_in = w[W-1-k];
        end
        @(negedge clock); Rx_in = par;
        @(negedge clock); Rx_in = stop_bit; block_ready = rdy_stop;
        @(negedge clock); Rx_in = 1'b1;
    endtask

    task automatic check_outs(input string tag, input bit v, input logic [W-1:0] out,
                              input bit p, input bit f, input bit o);
        check({tag, " valid"}, W'(block_valid), W'(v));
        check({tag, " out"}, block_out, out);
        check({tag, " perr"}, W'(parity_err), W'(p));
        check({tag, " ferr"}, W'(framing_err), W'(f));
        check({tag, " ovf"}, W'(overflow), W'(o));
        check({tag, " busy"}, W'(busy), '0);
    endtask

    typedef struct {
        logic [W-1:0] blk;
        bit           flip_par;
        bit           stop_bit;
        bit           rdy;
        bit           rdy_stop;
        bit           exp_v;
        logic [W-1:0] exp_out;
        bit           exp_p;
        bit           exp_f;
        bit           exp_o;
        bit           exp_v_after;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic         m_v;
        logic [W-1:0] m_out;
        bit           any_pulse;

        tbl[0] = '{BLK_A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, BLK_A, 1'b0, 1'b0, 1'b0, 1'b0}; // good frame
        tbl[1] = '{BLK_A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, BLK_A, 1'b1, 1'b0, 1'b0, 1'b0}; // parity bad
        tbl[2] = '{BLK_B, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, BLK_A, 1'b0, 1'b1, 1'b0, 1'b0}; // stop 0 + parity bad
        tbl[3] = '{BLK_B, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, BLK_B, 1'b0, 1'b0, 1'b0, 1'b1}; // held, not ready
        tbl[4] = '{BLK_A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, BLK_A, 1'b0, 1'b0, 1'b0, 1'b0}; // accept+deliver same cycle

        // Reset state and idle line.
        #1 resetn = 1'b0;
        #1;
        check("rst valid", W'(block_valid), '0);
        check("rst out", block_out, '0);
        check("rst pulses", W'({parity_err, framing_err, overflow}), '0);
        check("rst busy", W'(busy), '0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        any_pulse = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (busy || block_valid || parity_err || framing_err || overflow) any_pulse = 1'b1;
        end
        check("idle quiet", W'(any_pulse), '0);

        // Table-driven frames; each row starts from the state the previous left.
        for (int i = 0; i < 5; i++) begin
            send_frame(tbl[i].blk, tbl[i].flip_par, tbl[i].stop_bit, tbl[i].rdy, tbl[i].rdy_stop);
            check_outs($sformatf("row%0d", i), tbl[i].exp_v, tbl[i].exp_out,
                       tbl[i].exp_p, tbl[i].exp_f, tbl[i].exp_o);
            @(negedge clock);
            check($sformatf("row%0d valid_after", i), W'(block_valid), W'(tbl[i].exp_v_after));
            check($sformatf("row%0d pulse_1cyc", i), W'({parity_err, framing_err, overflow}), '0);
        end

        // Two good frames with no ready: second overflows, first is held.
        send_frame(BLK_A, 1'b0, 1'b1, 1'b0, 1'b0);
        check_outs("ovfA", 1'b1, BLK_A, 1'b0, 1'b0, 1'b0);
        send_frame(BLK_B, 1'b0, 1'b1, 1'b0, 1'b0);
        check_outs("ovfB", 1'b1, BLK_A, 1'b0, 1'b0, 1'b1);
        @(negedge clock); block_ready = 1'b1;
        @(negedge clock); block_ready = 1'b0;
        check("ovf accept valid", W'(block_valid), '0);
        check("ovf accept hold", block_out, BLK_A);

        // Reset in the middle of a frame.
        @(negedge clock); Rx_in = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock); Rx_in = 1'($urandom_range(0, 1));
        end
        @(negedge clock);
        check("mid busy", W'(busy), 1);
        resetn = 1'b0; Rx_in = 1'b1;
        #1;
        check("mid rst busy", W'(busy), '0);
        check("mid rst out", block_out, '0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        any_pulse = 1'b0;
        repeat (140) begin
            @(negedge clock);
            if (busy || block_valid || parity_err || framing_err || overflow) any_pulse = 1'b1;
        end
        check("mid no pulses", W'(any_pulse), '0);
        send_frame(BLK_B, 1'b0, 1'b1, 1'b1, 1'b1);
        check_outs("after rst", 1'b1, BLK_B, 1'b0, 1'b0, 1'b0);
        @(negedge clock);

        // Randomized frames against a frame-level model of the output register.
        m_v   = 1'b0;
        m_out = BLK_B;
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] blk;
            bit flip, stopb, rdy, rdy_stop, e_p, e_f, e_o;
            blk      = {$urandom, $urandom, $urandom, $urandom};
            flip     = ($urandom_range(0, 3) == 0);
            stopb    = ($urandom_range(0, 7) != 0);
            rdy      = 1'($urandom_range(0, 1));
            rdy_stop = 1'($urandom_range(0, 1));
            send_frame(blk, flip, stopb, rdy, rdy_stop);
            if (rdy) m_v = 1'b0;                 // accepted during the frame body
            e_f = !stopb;
            e_p = stopb && flip;
            e_o = 1'b0;
            if (stopb && !flip) begin
                if (m_v && !rdy_stop) e_o = 1'b1;
                else begin m_out = blk; m_v = 1'b1; end
            end else if (rdy_stop) begin
                m_v = 1'b0;
            end
            check_outs($sformatf("rnd%0d", n), m_v, m_out, e_p, e_f, e_o);
            @(negedge clock);
            if (rdy_stop) m_v = 1'b0;
            check($sformatf("rnd%0d valid_after", n), W'(block_valid), W'(m_v));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
